// File: rtl/data_mem_lsu_pkg.sv
// data_mem_lsu_pkg: access size encodings and FSM state type shared by the LSU data memory.
package data_mem_lsu_pkg;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    typedef enum logic {IDLE, BEAT2} state_t;
endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: request/response handshake bundle between the memory stage and the LSU.
interface data_mem_lsu_if #(parameter int XLEN = 32, parameter int ADDR_W = 12);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu_lane_ram.sv
// data_mem_lsu_lane_ram: one byte lane of the data memory with a registered read port.
module data_mem_lsu_lane_ram #(
    parameter int LANE_W = 8,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              wren,
    input  logic              rden,
    input  logic [AW-1:0]     addr,
    input  logic [LANE_W-1:0] wrdata,
    output logic [LANE_W-1:0] rddata
);
    logic [LANE_W-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (wren) mem[addr] <= wrdata;
        if (rden) rddata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-lane data memory with load/store alignment, misaligned split and extension.
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int LANE_W         = 8,
    parameter int ADDR_W         = 12,
    parameter int ALLOW_MISALIGN = 1
) (
    input logic           clk,
    input logic           rst,
    data_mem_lsu_if.slave bus
);
    localparam int NUM_LANES = XLEN / LANE_W;
    localparam int OFS_W     = $clog2(NUM_LANES);
    localparam int WORD_AW   = ADDR_W - OFS_W;
    localparam int SPAN_W    = OFS_W + 4;
    localparam logic [1:0] MAX_SIZE = 2'(OFS_W);

    state_t               state_q, state_d;
    logic                 rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                 we_q, we_d, uns_q, uns_d, split_q, split_d;
    logic [1:0]           size_q, size_d;
    logic [OFS_W-1:0]     ofs_q, ofs_d;
    logic [WORD_AW-1:0]   word2_q, word2_d;
    logic [NUM_LANES-1:0] strb2_q, strb2_d;
    logic [XLEN-1:0]      wd2_q, wd2_d, hold_q, hold_d;

    logic [OFS_W-1:0]       ofs;
    logic [WORD_AW-1:0]     word, lane_addr;
    logic [SPAN_W-1:0]      nbytes, span, rbytes;
    logic                   illegal, mis, err, accept, beat2, sign;
    logic [2*NUM_LANES-1:0] strb_w;
    logic [2*XLEN-1:0]      wd_w;
    logic [XLEN-1:0]        lane_wdata, rddata, low, ext;
    logic [NUM_LANES-1:0]   lane_strb, wren, rden;

    assign bus.req_ready = (state_q == IDLE) & (~rsp_valid_q | bus.rsp_ready);
    assign accept  = bus.req_valid & bus.req_ready;
    assign beat2   = state_q == BEAT2;
    assign ofs     = bus.req_addr[OFS_W-1:0];
    assign word    = bus.req_addr[ADDR_W-1:OFS_W];
    assign nbytes  = SPAN_W'(1) << bus.req_size;
    assign span    = SPAN_W'(ofs) + nbytes;
    assign illegal = bus.req_size > MAX_SIZE;
    assign mis     = span > SPAN_W'(NUM_LANES);
    assign err     = illegal | (mis & ((ALLOW_MISALIGN == 0) | (&word)));
    // Strobes and data span two words; the upper half is the second beat of a split.
    assign strb_w  = ~({(2*NUM_LANES){1'b1}} << nbytes) << ofs;
    assign wd_w    = {{XLEN{1'b0}}, bus.req_wdata} << (ofs * LANE_W);

    always_comb begin
        lane_addr  = beat2 ? word2_q : word;
        lane_wdata = beat2 ? wd2_q : wd_w[XLEN-1:0];
        lane_strb  = beat2 ? strb2_q : (accept & ~err ? strb_w[NUM_LANES-1:0] : '0);
        wren       = lane_strb & {NUM_LANES{beat2 ? we_q : bus.req_we}};
        rden       = lane_strb & ~wren;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        data_mem_lsu_lane_ram #(.LANE_W(LANE_W), .AW(WORD_AW)) u_ram (
            .clk    (clk),
            .wren   (wren[l]),
            .rden   (rden[l]),
            .addr   (lane_addr),
            .wrdata (lane_wdata[l*LANE_W +: LANE_W]),
            .rddata (rddata[l*LANE_W +: LANE_W])
        );
    end

    always_comb begin
        state_d     = IDLE;
        rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        uns_d       = uns_q;
        split_d     = split_q;
        size_d      = size_q;
        ofs_d       = ofs_q;
        word2_d     = word2_q;
        strb2_d     = strb2_q;
        wd2_d       = wd2_q;
        hold_d      = hold_q;
        if (accept) begin
            we_d        = bus.req_we;
            uns_d       = bus.req_unsigned;
            size_d      = bus.req_size;
            ofs_d       = ofs;
            split_d     = mis & ~err;
            word2_d     = word + WORD_AW'(1);
            strb2_d     = strb_w[2*NUM_LANES-1:NUM_LANES];
            wd2_d       = wd_w[2*XLEN-1:XLEN];
            state_d     = (mis & ~err) ? BEAT2 : IDLE;
            rsp_valid_d = ~(mis & ~err);
            rsp_err_d   = err;
        end
        if (beat2) begin
            hold_d      = rddata;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            size_q      <= '0;
            ofs_q       <= '0;
            word2_q     <= '0;
            strb2_q     <= '0;
            wd2_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            split_q     <= split_d;
            size_q      <= size_d;
            ofs_q       <= ofs_d;
            word2_q     <= word2_d;
            strb2_q     <= strb2_d;
            wd2_q       <= wd2_d;
            hold_q      <= hold_d;
        end
    end

    // Lane outputs only change on an accepted beat, so a held response stays stable.
    always_comb begin
        low    = XLEN'((split_q ? {rddata, hold_q} : {{XLEN{1'b0}}, rddata}) >> (ofs_q * LANE_W));
        rbytes = SPAN_W'(1) << size_q;
        sign   = 1'b0;
        for (int i = 0; i < NUM_LANES; i++)
            if (SPAN_W'(i + 1) == rbytes) sign = low[i*LANE_W + LANE_W - 1];
        for (int i = 0; i < NUM_LANES; i++)
            ext[i*LANE_W +: LANE_W] = SPAN_W'(i) < rbytes ? low[i*LANE_W +: LANE_W] : {LANE_W{sign & ~uns_q}};
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (rsp_valid_q & ~we_q & ~rsp_err_q) ? ext : '0;
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: randomized scoreboard bench against a byte-array memory model, plus directed checks.
module tb_data_mem_lsu;
    import data_mem_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_lsu_if #(.XLEN(32), .ADDR_W(12)) bus ();
    data_mem_lsu_if #(.XLEN(32), .ADDR_W(12)) bus0 ();

    data_mem_lsu #(.XLEN(32), .LANE_W(8), .ADDR_W(12), .ALLOW_MISALIGN(1)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    data_mem_lsu #(.XLEN(32), .LANE_W(8), .ADDR_W(12), .ALLOW_MISALIGN(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  mem [4096];
    logic [32:0] exp_q [$];
    bit          rand_rdy = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Byte-addressed little-endian reference; returns {err, rdata}.
    function automatic logic [32:0] model(input logic we, input logic [1:0] size, input logic uns,
                                          input logic [11:0] addr, input logic [31:0] wd);
        int bytes = 1 << size;
        logic [31:0] v = 32'h0;
        if (size > 2 || (addr[1:0] + bytes > 4 && addr[11:2] == 10'h3FF)) return {1'b1, 32'h0};
        for (int i = 0; i < bytes; i++)
            if (we) mem[addr + i] = wd[8*i +: 8];
            else v[8*i +: 8] = mem[addr + i];
        if (!we && !uns && bytes < 4 && v[8*bytes-1]) v |= 32'hFFFFFFFF << (8 * bytes);
        return {1'b0, we ? 32'h0 : v};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            logic [32:0] e;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got a response, required none pending");
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e[31:0]);
                check("rsp_err", 32'(bus.rsp_err), 32'(e[32]));
            end
        end
    end

    always @(posedge clk) if (rand_rdy) #2 bus.rsp_ready = 1'($urandom_range(0, 1));

    task automatic fixed_ready(input logic v);
        rand_rdy = 1'b0;
        @(posedge clk);
        #3 bus.rsp_ready = v;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wd);
        bit rdy = 1'b0;
        int n = 0;
        bit split;
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            n++;
        end
        #1 bus.req_valid = 1'b0;
        if (!rdy) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no req_ready in %0d cycles, required acceptance", n);
            return;
        end
        split = size <= 2 && (addr[1:0] + (1 << size)) > 4 && addr[11:2] != 10'h3FF;
        exp_q.push_back(model(we, size, uns, addr, wd));
        if (split) begin
            check("split_req_ready", 32'(bus.req_ready), 32'd0);
            check("split_rsp_valid_n1", 32'(bus.rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("rsp_valid_latency", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic req0(input logic we, input logic [1:0] size, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e, input string name);
        bus0.req_valid = 1'b1;
        bus0.req_we = we;
        bus0.req_size = size;
        bus0.req_unsigned = 1'b0;
        bus0.req_addr = addr;
        bus0.req_wdata = wd;
        @(negedge clk);
        check({name, "_ready"}, 32'(bus0.req_ready), 32'd1);
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        check({name, "_valid"}, 32'(bus0.rsp_valid), 32'd1);
        check({name, "_err"}, 32'(bus0.rsp_err), 32'(exp_e));
        check({name, "_rdata"}, bus0.rsp_rdata, exp_d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = SIZE_B;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_we = 1'b0;
        bus0.req_size = SIZE_B;
        bus0.req_unsigned = 1'b0;
        bus0.req_addr = '0;
        bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int w = 0; w < 1024; w++) do_req(1'b1, SIZE_W, 1'b0, 12'(w * 4), $urandom());
        do_req(1'b1, SIZE_W, 1'b0, 12'h010, 32'hDEADBEEF);
        do_req(1'b0, SIZE_W, 1'b0, 12'h010, 32'h0);
        do_req(1'b0, SIZE_B, 1'b0, 12'h013, 32'h0);
        do_req(1'b0, SIZE_B, 1'b1, 12'h013, 32'h0);
        do_req(1'b0, SIZE_H, 1'b0, 12'h012, 32'h0);
        do_req(1'b0, SIZE_H, 1'b1, 12'h010, 32'h0);
        do_req(1'b1, SIZE_H, 1'b0, 12'h011, 32'hFFFF1234);
        do_req(1'b0, SIZE_W, 1'b0, 12'h010, 32'h0);
        do_req(1'b0, SIZE_W, 1'b0, 12'h00C, 32'h0);
        do_req(1'b0, SIZE_W, 1'b0, 12'h014, 32'h0);
        do_req(1'b1, SIZE_W, 1'b0, 12'h023, 32'hA1B2C3D4);
        do_req(1'b0, SIZE_W, 1'b0, 12'h023, 32'h0);
        do_req(1'b1, SIZE_B, 1'b0, 12'h027, 32'h0);
        do_req(1'b0, SIZE_W, 1'b0, 12'h024, 32'h0);
        do_req(1'b0, SIZE_W, 1'b0, 12'hFFD, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 12'h100, 32'h0);
        do_req(1'b1, 2'd3, 1'b0, 12'h100, 32'h5A5A5A5A);
        do_req(1'b0, SIZE_W, 1'b0, 12'h100, 32'h0);
        fixed_ready(1'b0);
        do_req(1'b0, SIZE_W, 1'b0, 12'h010, 32'h0);
        repeat (4) begin
            check("hold_rdata", bus.rsp_rdata, exp_q[0][31:0]);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        fixed_ready(1'b1);
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            logic [11:0] a;
            a = 12'($urandom_range(0, 1023) * 4);
            do_req(1'b1, SIZE_W, 1'b0, a, $urandom());
            do_req(1'b0, SIZE_W, 1'b0, a, 32'h0);
        end
        check("b2b_cycles", 32'(cyc - c0), 32'd16);
        rand_rdy = 1'b1;
        repeat (400) begin
            logic [1:0]  sz;
            logic [11:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 7) == 0) ? 12'hFF8 + 12'($urandom_range(0, 7)) : 12'($urandom());
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
        end
        fixed_ready(1'b1);
        drain();
        req0(1'b1, SIZE_W, 12'h020, 32'h11223344, 32'h0, 1'b0, "m0_sw");
        req0(1'b1, SIZE_W, 12'h024, 32'h55667788, 32'h0, 1'b0, "m0_sw2");
        req0(1'b1, SIZE_W, 12'h023, 32'hA1B2C3D4, 32'h0, 1'b1, "m0_sw_mis");
        req0(1'b0, SIZE_W, 12'h020, 32'h0, 32'h11223344, 1'b0, "m0_lw");
        req0(1'b0, SIZE_W, 12'h024, 32'h0, 32'h55667788, 1'b0, "m0_lw2");
        req0(1'b0, SIZE_H, 12'h021, 32'h0, 32'h00002233, 1'b0, "m0_lh");
        req0(1'b0, SIZE_W, 12'h022, 32'h0, 32'h0, 1'b1, "m0_lw_mis");
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = SIZE_W;
        bus.req_addr = 12'h7FE;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("beat2_req_ready", 32'(bus.req_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst_beat2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_beat2_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rst_beat2_rsp_valid_later", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(1'b0, SIZE_W, 1'b0, 12'h010, 32'h0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
